// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: AXI4 burst address generator (FIXED/INCR/WRAP).
// Accepts one AW/AR-style command and emits one beat descriptor per transfer
// (address, byte strobe, index, LAST, ID). Illegal commands are rejected with
// a one-cycle cmd_err pulse and emit no beats.
// Optional build macro: AXI_BURST_4K_CHECK_EN -- when defined, an INCR burst
// whose last byte lies past the 4 KiB page of its start address is rejected.
module axi_burst_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  // beat descriptor channel
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [STRB_WIDTH-1:0] beat_strb,
  output logic [7:0]            beat_idx,
  output logic                  beat_last,
  output logic [ID_WIDTH-1:0]   beat_id,
  // rejection report
  output logic                  cmd_err,
  output logic [ID_WIDTH-1:0]   err_id
);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [STRB_WIDTH:0] LANE_ONE = (STRB_WIDTH + 1)'(1);

`ifdef AXI_BURST_4K_CHECK_EN
  localparam int unsigned PAGE_BYTES = 4096;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_ERR   = 2'd2
  } state_e;

  state_e                 state_q;

  // latched command context
  logic [1:0]             burst_q;
  logic [2:0]             size_q;
  logic [7:0]             len_q;
  logic [ADDR_WIDTH-1:0]  wrap_lo_q;
  logic [ADDR_WIDTH-1:0]  wrap_hi_q;

  // registered outputs
  logic                   beat_valid_q;
  logic [ADDR_WIDTH-1:0]  beat_addr_q;
  logic [STRB_WIDTH-1:0]  beat_strb_q;
  logic [7:0]             beat_idx_q;
  logic                   beat_last_q;
  logic [ID_WIDTH-1:0]    beat_id_q;
  logic                   cmd_err_q;
  logic [ID_WIDTH-1:0]    err_id_q;

  // command decode
  logic [31:0]            cmd_bytes_c;
  logic [31:0]            cmd_total_c;
  logic                   cmd_illegal_c;
  logic [ADDR_WIDTH-1:0]  cmd_wrap_lo_c;
  logic [ADDR_WIDTH-1:0]  cmd_wrap_hi_c;
  logic [STRB_WIDTH-1:0]  cmd_strb_c;

  // next-beat datapath
  logic [31:0]            cur_bytes_c;
  logic [ADDR_WIDTH-1:0]  step_addr_c;
  logic [ADDR_WIDTH-1:0]  beat_addr_d;
  logic [STRB_WIDTH-1:0]  beat_strb_d;
  logic [7:0]             beat_idx_d;

  // Active lanes run from the address offset within the bus word up to the
  // end of the size-aligned transfer containing that address.
  function automatic logic [STRB_WIDTH-1:0] calc_strb(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size
  );
    logic [31:0]           nbytes;
    logic [31:0]           lo;
    logic [31:0]           hi;
    logic [ADDR_WIDTH-1:0] lane_mask;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [STRB_WIDTH:0]   upto;
    logic [STRB_WIDTH:0]   below;
    nbytes    = 32'd1 << size;
    lane_mask = ADDR_WIDTH'(STRB_WIDTH - 1);
    aligned   = addr & ~ADDR_WIDTH'(nbytes - 32'd1);
    lo        = 32'(addr & lane_mask);
    hi        = 32'(aligned & lane_mask) + nbytes - 32'd1;
    upto      = (LANE_ONE << (hi + 32'd1)) - LANE_ONE;
    below     = (LANE_ONE << lo) - LANE_ONE;
    return STRB_WIDTH'(upto & ~below);
  endfunction

  // Decode the offered command: legality, wrap window and first strobe.
  always_comb begin
    cmd_bytes_c   = 32'd1 << cmd_size;
    cmd_total_c   = (32'(cmd_len) + 32'd1) << cmd_size;
    cmd_illegal_c = 1'b0;
    if (cmd_bytes_c > STRB_WIDTH) begin
      cmd_illegal_c = 1'b1;
    end
    if (cmd_burst == BURST_RSVD) begin
      cmd_illegal_c = 1'b1;
    end
    if (cmd_burst == BURST_WRAP) begin
      if (!((cmd_len == 8'd1) || (cmd_len == 8'd3) ||
            (cmd_len == 8'd7) || (cmd_len == 8'd15))) begin
        cmd_illegal_c = 1'b1;
      end
      if ((cmd_addr & ADDR_WIDTH'(cmd_bytes_c - 32'd1)) != '0) begin
        cmd_illegal_c = 1'b1;
      end
    end
    if ((cmd_burst == BURST_FIXED) && (cmd_len > 8'd15)) begin
      cmd_illegal_c = 1'b1;
    end
`ifdef AXI_BURST_4K_CHECK_EN
    // last byte offset relative to the start page; beyond the page -> reject
    if (cmd_burst == BURST_INCR) begin
      if (((32'(cmd_addr & ADDR_WIDTH'(PAGE_BYTES - 1)) & ~(cmd_bytes_c - 32'd1))
           + cmd_total_c - 32'd1) >= PAGE_BYTES) begin
        cmd_illegal_c = 1'b1;
      end
    end
`endif
    cmd_wrap_lo_c = cmd_addr & ~ADDR_WIDTH'(cmd_total_c - 32'd1);
    cmd_wrap_hi_c = cmd_wrap_lo_c + ADDR_WIDTH'(cmd_total_c);
    cmd_strb_c    = calc_strb(cmd_addr, cmd_size);
  end

  // Compute the descriptor of the beat following the current one.
  always_comb begin
    cur_bytes_c = 32'd1 << size_q;
    step_addr_c = (beat_addr_q & ~ADDR_WIDTH'(cur_bytes_c - 32'd1))
                  + ADDR_WIDTH'(cur_bytes_c);
    beat_addr_d = step_addr_c;
    case (burst_q)
      BURST_FIXED: beat_addr_d = beat_addr_q;
      BURST_WRAP:  beat_addr_d = (step_addr_c == wrap_hi_q) ? wrap_lo_q : step_addr_c;
      default:     beat_addr_d = step_addr_c;
    endcase
    beat_strb_d = calc_strb(beat_addr_d, size_q);
    beat_idx_d  = beat_idx_q + 8'd1;
  end

  // Control FSM with registered command context and beat outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      burst_q      <= 2'd0;
      size_q       <= 3'd0;
      len_q        <= 8'd0;
      wrap_lo_q    <= '0;
      wrap_hi_q    <= '0;
      beat_valid_q <= 1'b0;
      beat_addr_q  <= '0;
      beat_strb_q  <= '0;
      beat_idx_q   <= 8'd0;
      beat_last_q  <= 1'b0;
      beat_id_q    <= '0;
      cmd_err_q    <= 1'b0;
      err_id_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_err_q <= 1'b0;
          if (cmd_valid) begin
            if (cmd_illegal_c) begin
              state_q   <= ST_ERR;
              cmd_err_q <= 1'b1;
              err_id_q  <= cmd_id;
            end else begin
              state_q      <= ST_BURST;
              burst_q      <= cmd_burst;
              size_q       <= cmd_size;
              len_q        <= cmd_len;
              wrap_lo_q    <= cmd_wrap_lo_c;
              wrap_hi_q    <= cmd_wrap_hi_c;
              beat_valid_q <= 1'b1;
              beat_addr_q  <= cmd_addr;
              beat_strb_q  <= cmd_strb_c;
              beat_idx_q   <= 8'd0;
              beat_last_q  <= (cmd_len == 8'd0);
              beat_id_q    <= cmd_id;
            end
          end
        end
        ST_BURST: begin
          if (beat_ready) begin
            if (beat_last_q) begin
              state_q      <= ST_IDLE;
              beat_valid_q <= 1'b0;
              beat_last_q  <= 1'b0;
            end else begin
              beat_addr_q <= beat_addr_d;
              beat_strb_q <= beat_strb_d;
              beat_idx_q  <= beat_idx_d;
              beat_last_q <= (beat_idx_d == len_q);
            end
          end
        end
        ST_ERR: begin
          state_q   <= ST_IDLE;
          cmd_err_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          beat_valid_q <= 1'b0;
          beat_last_q  <= 1'b0;
          cmd_err_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE) & ARESETn;
  assign beat_valid = beat_valid_q;
  assign beat_addr  = beat_addr_q;
  assign beat_strb  = beat_strb_q;
  assign beat_idx   = beat_idx_q;
  assign beat_last  = beat_last_q;
  assign beat_id    = beat_id_q;
  assign cmd_err    = cmd_err_q;
  assign err_id     = err_id_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen (32-bit address and data, 8-bit ID).
// Honours AXI_BURST_4K_CHECK_EN for the page-crossing case.
module tb_axi_burst_addr_gen;

  logic        ACLK;
  logic        ARESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [7:0]  cmd_id;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic [7:0]  beat_id;
  logic        cmd_err;
  logic [7:0]  err_id;

  int errors = 0;
  int checks = 0;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .STRB_WIDTH (4),
    .ID_WIDTH   (8)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .cmd_id     (cmd_id),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_strb  (beat_strb),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .beat_id    (beat_id),
    .cmd_err    (cmd_err),
    .err_id     (err_id)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [7:0] idx, input logic last, input logic [7:0] id);
    chk({tag, ".valid"}, 64'(beat_valid), 64'd1);
    chk({tag, ".addr"},  64'(beat_addr),  64'(addr));
    chk({tag, ".strb"},  64'(beat_strb),  64'(strb));
    chk({tag, ".idx"},   64'(beat_idx),   64'(idx));
    chk({tag, ".last"},  64'(beat_last),  64'(last));
    chk({tag, ".id"},    64'(beat_id),    64'(id));
  endtask

  // Offer one command in an IDLE cycle; returns just after the handshake edge.
  task automatic send(input string tag, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input logic [7:0] id);
    chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    cmd_id    = id;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".beat_valid"}, 64'(beat_valid), 64'd0);
    chk({tag, ".cmd_ready"},  64'(cmd_ready),  64'd1);
  endtask

  initial begin
    ARESETn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_size   = '0;
    cmd_burst  = '0;
    cmd_id     = '0;
    beat_ready = 1'b1;

    // reset state
    tick();
    tick();
    chk("rst.cmd_ready",  64'(cmd_ready),  64'd0);
    chk("rst.beat_valid", 64'(beat_valid), 64'd0);
    chk("rst.cmd_err",    64'(cmd_err),    64'd0);
    chk("rst.beat_last",  64'(beat_last),  64'd0);
    chk("rst.beat_addr",  64'(beat_addr),  64'd0);
    ARESETn = 1'b1;
    tick();
    chk("rel.cmd_ready",  64'(cmd_ready),  64'd1);

    // INCR unaligned start, halfword beats
    send("incr", 32'h1002, 8'd3, 3'd1, 2'd1, 8'h11);
    chk_beat("incr.b0", 32'h1002, 4'b1100, 8'd0, 1'b0, 8'h11); tick();
    chk_beat("incr.b1", 32'h1004, 4'b0011, 8'd1, 1'b0, 8'h11); tick();
    chk_beat("incr.b2", 32'h1006, 4'b1100, 8'd2, 1'b0, 8'h11); tick();
    chk_beat("incr.b3", 32'h1008, 4'b0011, 8'd3, 1'b1, 8'h11); tick();
    chk_idle("incr.end");

    // WRAP across the 16-byte window
    send("wrap", 32'h38, 8'd3, 3'd2, 2'd2, 8'h22);
    chk_beat("wrap.b0", 32'h38, 4'b1111, 8'd0, 1'b0, 8'h22); tick();
    chk_beat("wrap.b1", 32'h3C, 4'b1111, 8'd1, 1'b0, 8'h22); tick();
    chk_beat("wrap.b2", 32'h30, 4'b1111, 8'd2, 1'b0, 8'h22); tick();
    chk_beat("wrap.b3", 32'h34, 4'b1111, 8'd3, 1'b1, 8'h22); tick();
    chk_idle("wrap.end");

    // WRAP with len 2 is rejected
    send("wrapbad", 32'h38, 8'd2, 3'd2, 2'd2, 8'h33);
    chk("wrapbad.cmd_err",    64'(cmd_err),    64'd1);
    chk("wrapbad.err_id",     64'(err_id),     64'h33);
    chk("wrapbad.beat_valid", 64'(beat_valid), 64'd0);
    chk("wrapbad.cmd_ready",  64'(cmd_ready),  64'd0);
    tick();
    chk("wrapbad.pulse_end",  64'(cmd_err),    64'd0);
    chk_idle("wrapbad.end");

    // FIXED with a three-cycle stall after beat 0
    send("fixed", 32'h101, 8'd2, 3'd0, 2'd0, 8'h44);
    chk_beat("fixed.b0", 32'h101, 4'b0010, 8'd0, 1'b0, 8'h44); tick();
    beat_ready = 1'b0;
    chk_beat("fixed.stall0", 32'h101, 4'b0010, 8'd1, 1'b0, 8'h44); tick();
    chk_beat("fixed.stall1", 32'h101, 4'b0010, 8'd1, 1'b0, 8'h44); tick();
    chk_beat("fixed.stall2", 32'h101, 4'b0010, 8'd1, 1'b0, 8'h44); tick();
    beat_ready = 1'b1;
    chk_beat("fixed.b1", 32'h101, 4'b0010, 8'd1, 1'b0, 8'h44); tick();
    chk_beat("fixed.b2", 32'h101, 4'b0010, 8'd2, 1'b1, 8'h44); tick();
    chk_idle("fixed.end");

    // INCR crossing a 4 KiB page
    send("page", 32'hFF8, 8'd3, 3'd2, 2'd1, 8'h55);
`ifdef AXI_BURST_4K_CHECK_EN
    chk("page.cmd_err",    64'(cmd_err),    64'd1);
    chk("page.err_id",     64'(err_id),     64'h55);
    chk("page.beat_valid", 64'(beat_valid), 64'd0);
    tick();
    chk("page.pulse_end",  64'(cmd_err),    64'd0);
`else
    chk_beat("page.b0", 32'hFF8,  4'b1111, 8'd0, 1'b0, 8'h55); tick();
    chk_beat("page.b1", 32'hFFC,  4'b1111, 8'd1, 1'b0, 8'h55); tick();
    chk_beat("page.b2", 32'h1000, 4'b1111, 8'd2, 1'b0, 8'h55); tick();
    chk_beat("page.b3", 32'h1004, 4'b1111, 8'd3, 1'b1, 8'h55); tick();
`endif
    chk_idle("page.end");

    // Size larger than the bus, then a legal command at the next IDLE cycle
    send("size3", 32'h200, 8'd1, 3'd3, 2'd1, 8'h66);
    chk("size3.cmd_err",    64'(cmd_err),    64'd1);
    chk("size3.err_id",     64'(err_id),     64'h66);
    chk("size3.beat_valid", 64'(beat_valid), 64'd0);
    tick();
    send("after", 32'h200, 8'd1, 3'd2, 2'd1, 8'h5A);
    chk("after.cmd_err", 64'(cmd_err), 64'd0);
    chk_beat("after.b0", 32'h200, 4'b1111, 8'd0, 1'b0, 8'h5A); tick();
    chk_beat("after.b1", 32'h204, 4'b1111, 8'd1, 1'b1, 8'h5A); tick();
    chk_idle("after.end");

    // Reserved burst type and FIXED longer than 16 beats
    send("rsvd", 32'h0, 8'd0, 3'd0, 2'd3, 8'h70);
    chk("rsvd.cmd_err", 64'(cmd_err), 64'd1);
    chk("rsvd.err_id",  64'(err_id),  64'h70);
    tick();
    send("fixlong", 32'h0, 8'd16, 3'd0, 2'd0, 8'h71);
    chk("fixlong.cmd_err", 64'(cmd_err), 64'd1);
    chk("fixlong.err_id",  64'(err_id),  64'h71);
    tick();

    // Reset in the middle of a len-7 INCR burst
    send("mid", 32'h0, 8'd7, 3'd2, 2'd1, 8'h77);
    chk_beat("mid.b0", 32'h0, 4'b1111, 8'd0, 1'b0, 8'h77); tick();
    chk_beat("mid.b1", 32'h4, 4'b1111, 8'd1, 1'b0, 8'h77); tick();
    chk_beat("mid.b2", 32'h8, 4'b1111, 8'd2, 1'b0, 8'h77);
    ARESETn = 1'b0;
    tick();
    chk("mid.rst.beat_valid", 64'(beat_valid), 64'd0);
    chk("mid.rst.cmd_ready",  64'(cmd_ready),  64'd0);
    chk("mid.rst.beat_last",  64'(beat_last),  64'd0);
    ARESETn = 1'b1;
    tick();
    chk("mid.rel.cmd_ready",  64'(cmd_ready),  64'd1);

    // Single-beat burst after reset release
    send("one", 32'h40, 8'd0, 3'd0, 2'd1, 8'h78);
    chk_beat("one.b0", 32'h40, 4'b0001, 8'd0, 1'b1, 8'h78); tick();
    chk_idle("one.end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
